// File: rtl/i2c_slot_arbiter_pkg.sv
// Shared state encodings and domain identifiers for the I2C slot arbiter.
// Pure definitions: no logic, no latency, no flow control.
package i2c_slot_arbiter_pkg;

    localparam logic [2:0] ARB_ST_IDLE  = 3'd0;
    localparam logic [2:0] ARB_ST_ISSUE = 3'd1;
    localparam logic [2:0] ARB_ST_WAIT  = 3'd2;
    localparam logic [2:0] ARB_ST_RESP  = 3'd3;
    localparam logic [2:0] ARB_ST_DRAIN = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ARB_ST_IDLE,
        ST_ISSUE = ARB_ST_ISSUE,
        ST_WAIT  = ARB_ST_WAIT,
        ST_RESP  = ARB_ST_RESP,
        ST_DRAIN = ARB_ST_DRAIN
    } arb_state_t;

    localparam logic DOM_D1 = 1'b0;
    localparam logic DOM_D2 = 1'b1;

endpackage

// File: rtl/i2c_slot_timer.sv
// Free-running slot counter: slot owner and "enough time left to issue" flag.
// Counter advances every clock; can_issue is combinational from the registered count; no backpressure.
module i2c_slot_timer
    import i2c_slot_arbiter_pkg::*;
#(
    parameter int SLOT_BITS    = 19,
    parameter int GUARD_CYCLES = 420000
) (
    input  logic clk,
    input  logic rst,
    output logic domain_i2c,
    output logic can_issue
);

    localparam int SLOT_LEN = 1 << SLOT_BITS;
    // A guard longer than the slot means no read can ever fit.
    localparam bit NEVER_FITS = GUARD_CYCLES > SLOT_LEN;
    localparam logic [SLOT_BITS:0] ISSUE_LIMIT =
        NEVER_FITS ? '0 : (SLOT_BITS + 1)'(SLOT_LEN - GUARD_CYCLES);

    logic [SLOT_BITS:0] slot_cnt;
    logic [SLOT_BITS:0] slot_pos_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
        end else begin
            slot_cnt <= slot_cnt + {{SLOT_BITS{1'b0}}, 1'b1};
        end
    end

    assign domain_i2c   = slot_cnt[SLOT_BITS];
    assign slot_pos_ext = {1'b0, slot_cnt[SLOT_BITS-1:0]};
    assign can_issue    = !NEVER_FITS && (slot_pos_ext <= ISSUE_LIMIT);

endmodule

// File: rtl/i2c_slot_arbiter.sv
// Time-slot arbiter sharing one I2C master sequencer between two security domains.
// Req to sys_start 2 clk min; requests are held pending (busy) until their own slot has room.
module i2c_slot_arbiter
    import i2c_slot_arbiter_pkg::*;
#(
    parameter int SLOT_BITS    = 19,
    parameter int GUARD_CYCLES = 420000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       domain_i2c,
    input  logic       d1_req,
    input  logic [6:0] d1_addr,
    output logic       d1_busy,
    output logic       d1_valid,
    output logic [7:0] d1_data,
    output logic       d1_err,
    input  logic       d2_req,
    input  logic [6:0] d2_addr,
    output logic       d2_busy,
    output logic       d2_valid,
    output logic [7:0] d2_data,
    output logic       d2_err,
    output logic       sys_start,
    output logic [6:0] sys_addr,
    input  logic       sys_done,
    input  logic [7:0] sys_rd_data
);

    logic            can_issue;
    logic [1:0]      pend;
    logic [1:0][6:0] req_addr;
    logic [1:0]      valid_q;
    logic [1:0]      err_q;
    logic [1:0][7:0] data_q;
    logic            own;
    arb_state_t      state;

    i2c_slot_timer #(
        .SLOT_BITS   (SLOT_BITS),
        .GUARD_CYCLES(GUARD_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .domain_i2c(domain_i2c),
        .can_issue (can_issue)
    );

    assign d1_busy  = pend[DOM_D1];
    assign d1_valid = valid_q[DOM_D1];
    assign d1_data  = data_q[DOM_D1];
    assign d1_err   = err_q[DOM_D1];
    assign d2_busy  = pend[DOM_D2];
    assign d2_valid = valid_q[DOM_D2];
    assign d2_data  = data_q[DOM_D2];
    assign d2_err   = err_q[DOM_D2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            own       <= DOM_D1;
            pend      <= '0;
            req_addr  <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            data_q    <= '0;
            sys_start <= 1'b0;
            sys_addr  <= '0;
        end else begin
            valid_q   <= '0;
            err_q     <= '0;
            data_q    <= '0;
            sys_start <= 1'b0;

            if (d1_req && !pend[DOM_D1]) begin
                pend[DOM_D1]     <= 1'b1;
                req_addr[DOM_D1] <= d1_addr;
            end
            if (d2_req && !pend[DOM_D2]) begin
                pend[DOM_D2]     <= 1'b1;
                req_addr[DOM_D2] <= d2_addr;
            end

            // pend clears below are written after the capture so they take priority.
            case (state)
                ST_IDLE: begin
                    if (pend[domain_i2c] && can_issue) begin
                        own       <= domain_i2c;
                        sys_start <= 1'b1;
                        sys_addr  <= req_addr[domain_i2c];
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (domain_i2c != own) begin
                        // Slot already flipped: any data now belongs to a closed slot.
                        if (sys_done) begin
                            err_q[own] <= 1'b1;
                            pend[own]  <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (sys_done) begin
                        valid_q[own] <= 1'b1;
                        data_q[own]  <= sys_rd_data;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    pend[own] <= 1'b0;
                    state     <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (sys_done) begin
                        err_q[own] <= 1'b1;
                        pend[own]  <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
